// File: rtl/scanline_reader_pkg.sv
// Shared definitions for the scanline reader.
// Holds the FSM state encoding and the buffer geometry: BUF_DEPTH bytes,
// ADDR_W-bit byte address and PIX_W-bit shade width.
package scanline_reader_pkg;

  localparam int BUF_DEPTH = 32;
  localparam int ADDR_W    = 5;
  localparam int PIX_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/scanline_reader_palette_map.sv
// Combinational BGP-style palette lookup.
// Ports:
//   idx     - 2-bit colour index taken from the packed pixel byte
//   palette - 8-bit map; the shade for index i sits at palette[2i+1:2i]
//   shade   - 2-bit mapped shade
module palette_map
  import scanline_reader_pkg::*;
(
  input  logic [PIX_W-1:0] idx,
  input  logic [7:0]       palette,
  output logic [PIX_W-1:0] shade
);

  always_comb begin
    shade = palette[1:0];
    case (idx)
      2'd0:    shade = palette[1:0];
      2'd1:    shade = palette[3:2];
      2'd2:    shade = palette[5:4];
      default: shade = palette[7:6];
    endcase
  end

endmodule

// File: rtl/scanline_reader.sv
// Drains one scanline of 2bpp packed bytes from an asynchronous-read
// buffer and streams the palette-mapped shades over a valid/ready port.
// Each byte holds four pixels, MSB pair first; one FETCH bubble separates
// consecutive bytes.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - one-cycle request to drain a line (IDLE only)
//   abort               - synchronous line cancel, highest priority
//   palette             - palette map, captured when the line starts
//   rd_addr / rd_data   - buffer read port (data valid in the same cycle)
//   pix_data, pix_valid - mapped shade and its qualifier
//   pix_ready           - downstream accept
//   busy                - high whenever the FSM is not IDLE
//   line_done           - one-cycle pulse after the last pixel is accepted
module scanline_reader
  import scanline_reader_pkg::*;
#(
  parameter int LINE_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        palette,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              line_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_BYTES - 1);

  state_t            state;
  logic [7:0]        shift;
  logic [1:0]        cnt;
  logic [7:0]        pal_q;
  logic [PIX_W-1:0]  map_idx;
  logic [PIX_W-1:0]  map_shade;
  logic              xfer;

  assign xfer = pix_valid & pix_ready;

  // pix_data is registered, so the shade is looked up one step ahead:
  // in FETCH for the first pixel of the incoming byte, in SHIFT for the
  // pair that becomes the top of the shift register after the shift.
  assign map_idx = (state == FETCH) ? rd_data[7:6] : shift[5:4];

  palette_map u_map (
    .idx     (map_idx),
    .palette (pal_q),
    .shade   (map_shade)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      shift     <= '0;
      cnt       <= '0;
      pal_q     <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      line_done <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      rd_addr   <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      line_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pal_q   <= palette;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          shift     <= rd_data;
          cnt       <= '0;
          pix_data  <= map_shade;
          pix_valid <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (xfer) begin
            if (cnt != 2'd3) begin
              shift    <= shift << 2;
              cnt      <= cnt + 2'd1;
              pix_data <= map_shade;
            end else if (rd_addr != LAST_ADDR) begin
              rd_addr   <= rd_addr + 1'b1;
              pix_valid <= 1'b0;
              state     <= FETCH;
            end else begin
              // Last pixel of the line: hold rd_addr, no wrap.
              pix_valid <= 1'b0;
              line_done <= 1'b1;
              state     <= DONE;
            end
          end
        end
        default: begin
          line_done <= 1'b0;
          busy      <= 1'b0;
          rd_addr   <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scanline_reader.sv
module tb_scanline_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] palette;
  logic       pix_ready;
  logic       abort;

  logic       start1, start32;
  logic [4:0] rd_addr1, rd_addr32;
  logic [7:0] rd_data1, rd_data32;
  logic [1:0] pix_data1, pix_data32;
  logic       pix_valid1, pix_valid32;
  logic       busy1, busy32;
  logic       line_done1, line_done32;

  logic [7:0] mem1  [0:31];
  logic [7:0] mem32 [0:31];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rd_data1  = mem1[rd_addr1];
  assign rd_data32 = mem32[rd_addr32];

  scanline_reader #(.LINE_BYTES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .palette(palette), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .pix_data(pix_data1), .pix_valid(pix_valid1), .pix_ready(pix_ready),
    .busy(busy1), .line_done(line_done1)
  );

  scanline_reader #(.LINE_BYTES(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort),
    .palette(palette), .rd_addr(rd_addr32), .rd_data(rd_data32),
    .pix_data(pix_data32), .pix_valid(pix_valid32), .pix_ready(pix_ready),
    .busy(busy32), .line_done(line_done32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference shade of pixel k of the 32-byte line under palette pal.
  function automatic logic [1:0] exp_pix(input logic [7:0] pal, input int k);
    logic [7:0] b;
    logic [1:0] idx;
    int s;
    b   = mem32[k / 4];
    s   = k % 4;
    idx = b[7 - 2 * s -: 2];
    return pal[2 * idx +: 2];
  endfunction

  // Drain one 32-byte line. stall_at/abort_at/rst_at select a pixel index
  // at which to stall 10 cycles, abort, or assert reset (-1 = never).
  task automatic run32(input logic [7:0] pal, input int stall_at, input int abort_at,
                       input int rst_at, output int npix, output int ndone);
    int k;
    int stall;
    logic fin;
    k = 0; stall = 0; ndone = 0; fin = 1'b0;
    palette = pal;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b1;
    for (int cyc = 0; cyc < 800 && !fin; cyc++) begin
      @(posedge clk); #1;
      start32 = 1'b0;
      if (line_done32) ndone++;
      if (!busy32) begin
        fin = 1'b1;
      end else if (pix_valid32) begin
        chk("pix_data", pix_data32, exp_pix(pal, k));
        chk("rd_addr", rd_addr32, k / 4);
        if (k == 10) palette = ~pal;
        if (k == abort_at) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          chk("abort_busy", busy32, 0);
          chk("abort_valid", pix_valid32, 0);
          chk("abort_addr", rd_addr32, 0);
          chk("abort_done", line_done32, 0);
          for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            chk("abort_no_done", line_done32, 0);
          end
          fin = 1'b1;
        end else if (k == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_addr", rd_addr32, 0);
          chk("rst_valid", pix_valid32, 0);
          chk("rst_data", pix_data32, 0);
          chk("rst_busy", busy32, 0);
          chk("rst_done", line_done32, 0);
          @(posedge clk); #1;
          rst_n = 1'b1;
          fin = 1'b1;
        end else if (k == stall_at && stall < 10) begin
          pix_ready = 1'b0;
          stall++;
        end else begin
          pix_ready = 1'b1;
          start32 = (k == 20);
          k++;
        end
      end
    end
    if (!fin) chk("run32_timeout", 0, 1);
    pix_ready = 1'b1;
    npix = k;
  endtask

  typedef struct {
    logic [7:0] b;
    logic [7:0] pal;
    logic [7:0] exp;   // four expected shades, first pixel in [7:6]
  } vec_t;

  vec_t vecs [5];

  initial begin
    int npix;
    int ndone;
    vec_t v;
    logic [7:0] e;

    vecs[0] = '{b: 8'b00_01_10_11, pal: 8'hE4, exp: 8'b00_01_10_11};
    vecs[1] = '{b: 8'h1B,          pal: 8'h1B, exp: 8'b11_10_01_00};
    vecs[2] = '{b: 8'hFF,          pal: 8'hE4, exp: 8'b11_11_11_11};
    vecs[3] = '{b: 8'h00,          pal: 8'hC6, exp: 8'b10_10_10_10};
    vecs[4] = '{b: 8'hD8,          pal: 8'h9C, exp: 8'b10_11_01_00};

    for (int i = 0; i < 32; i++) begin
      mem1[i]  = 8'h00;
      mem32[i] = 8'(i * 29 + 7);
    end

    rst_n = 1'b0; palette = 8'h00; pix_ready = 1'b1; abort = 1'b0;
    start1 = 1'b0; start32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy1", busy1, 0);
    chk("reset_valid1", pix_valid1, 0);
    chk("reset_data1", pix_data1, 0);
    chk("reset_addr1", rd_addr1, 0);
    chk("reset_done1", line_done1, 0);
    chk("reset_busy32", busy32, 0);
    chk("reset_valid32", pix_valid32, 0);
    rst_n = 1'b1;

    // Single-byte lines: exact cycle-by-cycle timing and palette mapping.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      e = v.exp;
      mem1[0] = v.b;
      palette = v.pal;
      @(posedge clk); #1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      palette = ~v.pal;
      chk("fetch_busy", busy1, 1);
      chk("fetch_valid", pix_valid1, 0);
      chk("fetch_addr", rd_addr1, 0);
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        chk("vec_valid", pix_valid1, 1);
        chk("vec_pix", pix_data1, e[7 - 2 * j -: 2]);
        chk("vec_nodone", line_done1, 0);
      end
      @(posedge clk); #1;
      chk("vec_done", line_done1, 1);
      chk("vec_done_valid", pix_valid1, 0);
      chk("vec_done_busy", busy1, 1);
      chk("vec_done_addr", rd_addr1, 0);
      @(posedge clk); #1;
      chk("vec_done_pulse", line_done1, 0);
      chk("vec_idle_busy", busy1, 0);
    end

    // Full line, start pulsed mid-line, palette changed mid-line.
    run32(8'h1B, -1, -1, -1, npix, ndone);
    chk("full_npix", npix, 128);
    chk("full_ndone", ndone, 1);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("full_idle", busy32, 0);
    end

    // Backpressure on the second pixel.
    run32(8'hE4, 1, -1, -1, npix, ndone);
    chk("stall_npix", npix, 128);
    chk("stall_ndone", ndone, 1);

    // Abort at pixel 37, then a full replay from address 0.
    run32(8'h9C, -1, 37, -1, npix, ndone);
    chk("abort_npix", npix, 37);
    chk("abort_ndone", ndone, 0);
    run32(8'hE4, -1, -1, -1, npix, ndone);
    chk("replay_npix", npix, 128);
    chk("replay_ndone", ndone, 1);

    // Reset at pixel 50, then a full line after release.
    run32(8'h1B, -1, -1, 50, npix, ndone);
    chk("rst_npix", npix, 50);
    chk("rst_ndone", ndone, 0);
    run32(8'h1B, -1, -1, -1, npix, ndone);
    chk("post_rst_npix", npix, 128);
    chk("post_rst_ndone", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scanline_reader.md
SCANLINE_READER -- requirements
Module: scanline_reader

Interface
REQ-001 Parameter: LINE_BYTES, default 32, number of scanline buffer bytes drained per line, legal range 1..32.
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  single-cycle request to drain one line, sampled only in IDLE.
REQ-005 Port: abort  input  1  synchronous line cancel, takes priority over all other inputs except rst_n.
REQ-006 Port: palette  input  8  BGP-style map; shade for index i = palette[2i+1:2i].
REQ-007 Port: rd_addr  output  5  address to the scanline buffer combinational read port.
REQ-008 Port: rd_data  input  8  buffer byte at rd_addr, same cycle (asynchronous read).
REQ-009 Port: pix_data  output  2  mapped shade of the current pixel.
REQ-010 Port: pix_valid  output  1  pix_data is valid.
REQ-011 Port: pix_ready  input  1  downstream accepts pixel when high with pix_valid.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: line_done  output  1  one-cycle pulse after last pixel of the line is accepted.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, SHIFT, DONE.
REQ-015 IDLE: on start=1 (and abort=0), latch palette into pal_q, set rd_addr=0, go to FETCH; start SHALL be ignored in all other states.
REQ-016 FETCH: load rd_data into 8-bit shift register, clear 2-bit sub-pixel counter, go to SHIFT.
REQ-017 SHIFT: pix_valid=1; pix_data = pal_q shade indexed by shift[7:6] (2bpp packed, MSB pair first).
REQ-018 A transfer occurs when pix_valid and pix_ready are both 1; without a transfer, pix_data, shift and counter SHALL hold.
REQ-019 On transfer with counter<3: shift left by 2, counter+1, stay in SHIFT.
REQ-020 On transfer with counter=3 and rd_addr<LINE_BYTES-1: rd_addr+1, go to FETCH.
REQ-021 On transfer with counter=3 and rd_addr=LINE_BYTES-1: go to DONE; rd_addr SHALL NOT wrap.
REQ-022 DONE: line_done=1 for exactly one cycle, rd_addr returns to 0, go to IDLE.
REQ-023 Latency: start sampled at edge N -> FETCH in cycle N+1 -> first pix_valid in cycle N+2; one FETCH bubble per byte (peak 4 pixels per 5 cycles).
REQ-024 Total pixels per line SHALL be exactly 4*LINE_BYTES.
REQ-025 abort=1 in any state: go to IDLE next edge, rd_addr=0, pix_valid=0, no line_done pulse.
REQ-026 Palette changes during a line SHALL NOT affect that line (pal_q latched at start only).
REQ-027 pix_valid SHALL be 0 in IDLE, FETCH, DONE.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, rd_addr=0, shift=0, counter=0, pal_q=0, pix_data=0, pix_valid=0, busy=0, line_done=0.
REQ-029 Reset asserted mid-line SHALL discard the line; the first start after release begins at address 0.

Structure
REQ-030 Shared package SHALL hold state encodings, BUF_DEPTH=32, ADDR_W=5, PIX_W=2.
REQ-031 One sub-module palette_map (2-bit index, 8-bit palette -> 2-bit shade, combinational) SHALL be instantiated.

Verification
REQ-032 LINE_BYTES=1, mem[0]=8'b00_01_10_11, palette=8'hE4, pix_ready=1 -> pix_data 0,1,2,3 in cycles N+2..N+5, line_done at N+6.
REQ-033 palette=8'h1B, mem[0]=8'h1B -> pix_data 3,2,1,0 (inverted map).
REQ-034 LINE_BYTES=32, pix_ready=1 -> 128 pixels, rd_addr 0..31 monotonic, one line_done, busy falls after it.
REQ-035 pix_ready held 0 for 10 cycles on second pixel -> pix_data stable, no skip or duplicate.
REQ-036 abort at pixel 37 -> IDLE next cycle, no line_done; next start replays from address 0.
REQ-037 rst_n low at pixel 50, start pulsed during busy, palette changed mid-line -> reset values immediate; start ignored while busy; mid-line palette change has no effect.
